// File: rtl/dmem_responder_pkg.sv
// Shared constants and address decode for the data-memory responder.
// The timer block is built only when DMEM_TIMER_EN is defined.
package dmem_responder_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] DMEM_MMIO_BASE  = 12'h008;
  localparam logic [ADDR_W-1:0] DMEM_GPIO_OUT   = 12'h008;
  localparam logic [ADDR_W-1:0] DMEM_GPIO_IN    = 12'h009;
  localparam logic [ADDR_W-1:0] DMEM_TMR_CNT    = 12'h00A;
  localparam logic [ADDR_W-1:0] DMEM_TMR_RELOAD = 12'h00B;
  localparam logic [ADDR_W-1:0] DMEM_TMR_CTRL   = 12'h00C;
  localparam logic [ADDR_W-1:0] DMEM_ERR        = 12'h00D;
  localparam logic [ADDR_W-1:0] DMEM_RAM_BASE   = 12'h010;

  localparam int TMR_CTRL_RUN    = 0;
  localparam int TMR_CTRL_IRQ_EN = 1;
  localparam int TMR_CTRL_PEND   = 2;

  localparam logic [DATA_W-1:0] RDATA_UNMAPPED = 8'hFF;
  localparam logic [DATA_W-1:0] TMR_RELOAD_RST = 8'hFF;

  typedef enum logic [1:0] {
    REGION_RSVD,  // 0x000-0x007: silently ignored
    REGION_MMIO,  // 0x008-0x00F: peripheral window
    REGION_RAM,   // 0x010-RAM_DEPTH-1
    REGION_OOR    // beyond RAM: reads 0xFF, flags bus_err
  } region_e;

  function automatic region_e decode_region(input logic [ADDR_W-1:0] addr,
                                            input int                ram_depth);
    if (addr < DMEM_MMIO_BASE) return REGION_RSVD;
    if (addr < DMEM_RAM_BASE)  return REGION_MMIO;
    if (int'(addr) < ram_depth) return REGION_RAM;
    return REGION_OOR;
  endfunction

endpackage

// File: rtl/dmem_timer.sv
// Reload timer: prescaler, down-counter, sticky pend flag and registered irq.
// Only compiled when DMEM_TIMER_EN is defined.
`ifdef DMEM_TIMER_EN
module dmem_timer
  import dmem_responder_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reload_we,
  input  logic              ctrl_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] cnt,
  output logic [DATA_W-1:0] reload,
  output logic [DATA_W-1:0] ctrl,
  output logic              irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc;
  logic          run;
  logic          irq_en;
  logic          pend;
  logic          start;
  logic          tick;
  logic          expire;

  // A start only happens from the stopped state, so it never coincides with a tick.
  assign start  = ctrl_we & wdata[TMR_CTRL_RUN] & ~run;
  assign tick   = run & (presc == PW'(PRESCALE - 1));
  assign expire = tick & (cnt == '0);

  assign ctrl = {5'b0, pend, irq_en, run};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc  <= '0;
      cnt    <= '0;
      reload <= TMR_RELOAD_RST;
      run    <= 1'b0;
      irq_en <= 1'b0;
      pend   <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (!run || tick) presc <= '0;
      else              presc <= presc + PW'(1);

      if (start)       cnt <= reload;
      else if (expire) cnt <= reload;
      else if (tick)   cnt <= cnt - 8'd1;

      if (reload_we) reload <= wdata;

      if (ctrl_we) begin
        run    <= wdata[TMR_CTRL_RUN];
        irq_en <= wdata[TMR_CTRL_IRQ_EN];
      end

      if (expire)                            pend <= 1'b1;
      else if (ctrl_we && wdata[TMR_CTRL_PEND]) pend <= 1'b0;

      irq <= pend & irq_en;
    end
  end

endmodule
`endif

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory bus target with RAM, GPIO, reload timer and sticky bus_err.
// Timer registers and timer_irq exist only when DMEM_TIMER_EN is defined.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int RAM_DEPTH = 2048,
  parameter int PRESCALE  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_mem_en,
  input  logic              d_mem_rd,
  input  logic              d_mem_wr,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  input  logic [DATA_W-1:0] gpio_in,
  output logic [DATA_W-1:0] gpio_out,
  output logic              timer_irq,
  output logic              bus_err
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);

  if (RAM_DEPTH <= int'(DMEM_RAM_BASE) || RAM_DEPTH > (1 << ADDR_W)) begin : g_bad_ram_depth
    $error("dmem_responder: RAM_DEPTH must lie in 17..4096");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("dmem_responder: PRESCALE must be at least 1");
  end

  logic              rd;
  logic              wr;
  logic              access;
  region_e           region;
  logic              mmio_wr;
  logic              ram_we;
  logic              err_set;
  logic              err_clr;
  logic [DATA_W-1:0] gpio_meta;
  logic [DATA_W-1:0] gpio_sync;
  logic [DATA_W-1:0] tmr_cnt;
  logic [DATA_W-1:0] tmr_reload;
  logic [DATA_W-1:0] tmr_ctrl;
  logic [DATA_W-1:0] ram [RAM_DEPTH];

  assign rd      = d_mem_en & d_mem_rd;
  assign wr      = d_mem_en & d_mem_wr;
  assign access  = rd | wr;
  assign region  = decode_region(d_mem_addr, RAM_DEPTH);
  assign mmio_wr = wr & (region == REGION_MMIO);
  assign ram_we  = wr & (region == REGION_RAM);

  // Simultaneous rd+wr is a protocol error, but the reserved low window stays silent.
  assign err_set = access & ((region == REGION_OOR) |
                             (d_mem_rd & d_mem_wr & (region != REGION_RSVD)));
  assign err_clr = mmio_wr & (d_mem_addr == DMEM_ERR) & d_mem_wdata[0];

  // NOTE: every output of a combinational block gets a default before any branch,
  // otherwise paths that skip an assignment infer a latch.
  always_comb begin
    d_mem_rdata = '0;
    if (rd) begin
      case (region)
        REGION_MMIO: begin
          case (d_mem_addr)
            DMEM_GPIO_OUT:   d_mem_rdata = gpio_out;
            DMEM_GPIO_IN:    d_mem_rdata = gpio_sync;
            DMEM_TMR_CNT:    d_mem_rdata = tmr_cnt;
            DMEM_TMR_RELOAD: d_mem_rdata = tmr_reload;
            DMEM_TMR_CTRL:   d_mem_rdata = tmr_ctrl;
            DMEM_ERR:        d_mem_rdata = {7'b0, bus_err};
            default:         d_mem_rdata = '0;
          endcase
        end
        REGION_RAM: d_mem_rdata = ram[d_mem_addr[RAM_AW-1:0]];
        REGION_OOR: d_mem_rdata = RDATA_UNMAPPED;
        default:    d_mem_rdata = '0;
      endcase
    end
  end

  // NOTE: RAM contents are deliberately not reset so the array maps onto block RAM;
  // the reset term only drops a write that coincides with reset.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) ram[d_mem_addr[RAM_AW-1:0]] <= d_mem_wdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_out  <= '0;
      gpio_meta <= '0;
      gpio_sync <= '0;
      bus_err   <= 1'b0;
    end else begin
      gpio_meta <= gpio_in;
      gpio_sync <= gpio_meta;
      if (mmio_wr && d_mem_addr == DMEM_GPIO_OUT) gpio_out <= d_mem_wdata;
      if (err_set)      bus_err <= 1'b1;
      else if (err_clr) bus_err <= 1'b0;
    end
  end

`ifdef DMEM_TIMER_EN
  logic tmr_reload_we;
  logic tmr_ctrl_we;

  assign tmr_reload_we = mmio_wr & (d_mem_addr == DMEM_TMR_RELOAD);
  assign tmr_ctrl_we   = mmio_wr & (d_mem_addr == DMEM_TMR_CTRL);

  dmem_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .reload_we (tmr_reload_we),
    .ctrl_we   (tmr_ctrl_we),
    .wdata     (d_mem_wdata),
    .cnt       (tmr_cnt),
    .reload    (tmr_reload),
    .ctrl      (tmr_ctrl),
    .irq       (timer_irq)
  );
`else
  assign tmr_cnt    = '0;
  assign tmr_reload = '0;
  assign tmr_ctrl   = '0;
  assign timer_irq  = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized RAM traffic
// against a sparse-array reference model. Timer checks follow DMEM_TIMER_EN.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int RAM_DEPTH = 2048;
  localparam int PRESCALE  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_mem_en, d_mem_rd, d_mem_wr;
  logic [11:0] d_mem_addr;
  logic [7:0]  d_mem_wdata, d_mem_rdata;
  logic [7:0]  gpio_in, gpio_out;
  logic        timer_irq, bus_err;

  int errors = 0;
  int checks = 0;
  logic [7:0] mdl [int];

  always #5 clk = ~clk;

  dmem_responder #(.RAM_DEPTH(RAM_DEPTH), .PRESCALE(PRESCALE)) dut (
    .clk         (clk),
    .reset       (reset),
    .d_mem_en    (d_mem_en),
    .d_mem_rd    (d_mem_rd),
    .d_mem_wr    (d_mem_wr),
    .d_mem_addr  (d_mem_addr),
    .d_mem_wdata (d_mem_wdata),
    .d_mem_rdata (d_mem_rdata),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .timer_irq   (timer_irq),
    .bus_err     (bus_err)
  );

  task automatic drive(input logic en, input logic r, input logic w,
                       input logic [11:0] a, input logic [7:0] d);
    d_mem_en = en; d_mem_rd = r; d_mem_wr = w; d_mem_addr = a; d_mem_wdata = d;
    #1;
  endtask

  task automatic idle();                                   drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00); endtask
  task automatic rd(input logic [11:0] a);                 drive(1'b1, 1'b1, 1'b0, a, 8'h00);       endtask
  task automatic wr(input logic [11:0] a, input logic [7:0] d); drive(1'b1, 1'b0, 1'b1, a, d);       endtask
  task automatic step(); @(posedge clk); #2; endtask
  task automatic wr_step(input logic [11:0] a, input logic [7:0] d); wr(a, d); step(); idle(); endtask

  // Polls the pend bit once per cycle; n is the number of edges elapsed.
  task automatic wait_pend(input int budget, output int n, output bit found);
    n = 0; found = 1'b0;
    while (!found && n < budget) begin
      step(); n++;
      rd(DMEM_TMR_CTRL);
      found = d_mem_rdata[TMR_CTRL_PEND];
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_reload;
`ifdef DMEM_TIMER_EN
    exp_reload = 8'hFF;
`else
    exp_reload = 8'h00;
`endif
    reset = 1'b1; gpio_in = 8'h00; idle();
    repeat (2) @(posedge clk);
    #2;
    checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL reset_gpio_out: got %h want 00", gpio_out); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_timer_irq: got %b want 0", timer_irq); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    checks++; if (d_mem_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata_idle: got %h want 00", d_mem_rdata); end
    @(negedge clk) reset = 1'b0;
    step();
    rd(DMEM_TMR_RELOAD);
    checks++; if (d_mem_rdata !== exp_reload) begin errors++; $display("FAIL reset_tmr_reload: got %h want %h", d_mem_rdata, exp_reload); end
    rd(DMEM_TMR_CNT);
    checks++; if (d_mem_rdata !== 8'h00) begin errors++; $display("FAIL reset_tmr_cnt: got %h want 00", d_mem_rdata); end
    rd(DMEM_TMR_CTRL);
    checks++; if (d_mem_rdata !== 8'h00) begin errors++; $display("FAIL reset_tmr_ctrl: got %h want 00", d_mem_rdata); end
    rd(DMEM_GPIO_IN);
    checks++; if (d_mem_rdata !== 8'h00) begin errors++; $display("FAIL reset_gpio_in_sync: got %h want 00", d_mem_rdata); end
    idle();
  endtask

  task automatic test_ram_roundtrip();
    wr_step(12'h123, 8'h11);
    drive(1'b1, 1'b1, 1'b1, 12'h123, 8'hA5);
    checks++; if (d_mem_rdata !== 8'h11) begin errors++; $display("FAIL ram_read_during_write: got %h want 11", d_mem_rdata); end
    step();
    rd(12'h123);
    checks++; if (d_mem_rdata !== 8'hA5) begin errors++; $display("FAIL ram_next_cycle: got %h want A5", d_mem_rdata); end
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL ram_rdwr_err: got %b want 1", bus_err); end
    wr_step(DMEM_ERR, 8'h01);
  endtask

  task automatic test_stack();
    wr(12'h200, 8'h34); step();
    wr(12'h201, 8'h01); step();
    rd(12'h201);
    checks++; if (d_mem_rdata !== 8'h01) begin errors++; $display("FAIL stack_pop_hi: got %h want 01", d_mem_rdata); end
    step();
    rd(12'h200);
    checks++; if (d_mem_rdata !== 8'h34) begin errors++; $display("FAIL stack_pop_lo: got %h want 34", d_mem_rdata); end
    step(); idle();
  endtask

  task automatic test_bus_err_range();
    rd(12'h7FF); step(); idle();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL err_top_of_ram: got %b want 0", bus_err); end
    rd(12'h800);
    checks++; if (d_mem_rdata !== 8'hFF) begin errors++; $display("FAIL oor_rdata_800: got %h want FF", d_mem_rdata); end
    step(); idle();
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL oor_err_800: got %b want 1", bus_err); end
    wr_step(DMEM_ERR, 8'hFE);
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL err_clear_needs_bit0: got %b want 1", bus_err); end
    wr_step(DMEM_ERR, 8'h01);
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", bus_err); end
    rd(12'h900);
    checks++; if (d_mem_rdata !== 8'hFF) begin errors++; $display("FAIL oor_rdata_900: got %h want FF", d_mem_rdata); end
    step();
    rd(DMEM_ERR);
    checks++; if (d_mem_rdata !== 8'h01) begin errors++; $display("FAIL err_readback: got %h want 01", d_mem_rdata); end
    drive(1'b1, 1'b1, 1'b1, DMEM_ERR, 8'h01); step(); idle();
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %b want 1", bus_err); end
    wr_step(DMEM_ERR, 8'h01);
  endtask

  task automatic test_bus_err_rdwr();
    drive(1'b1, 1'b1, 1'b1, 12'h050, 8'h77); step(); idle();
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL rdwr_err: got %b want 1", bus_err); end
    rd(12'h050);
    checks++; if (d_mem_rdata !== 8'h77) begin errors++; $display("FAIL rdwr_write_done: got %h want 77", d_mem_rdata); end
    wr_step(DMEM_ERR, 8'h01);
  endtask

  task automatic test_low_addr();
    wr_step(12'h003, 8'h99);
    rd(12'h003);
    checks++; if (d_mem_rdata !== 8'h00) begin errors++; $display("FAIL low_addr_read: got %h want 00", d_mem_rdata); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL low_addr_no_err: got %b want 0", bus_err); end
    checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL low_addr_no_side_effect: got %h want 00", gpio_out); end
    idle();
  endtask

  task automatic test_gpio();
    wr_step(DMEM_GPIO_OUT, 8'h5A);
    checks++; if (gpio_out !== 8'h5A) begin errors++; $display("FAIL gpio_out_write: got %h want 5A", gpio_out); end
    rd(DMEM_GPIO_OUT);
    checks++; if (d_mem_rdata !== 8'h5A) begin errors++; $display("FAIL gpio_out_readback: got %h want 5A", d_mem_rdata); end
    gpio_in = 8'h3C;
    step();
    rd(DMEM_GPIO_IN);
    checks++; if (d_mem_rdata !== 8'h00) begin errors++; $display("FAIL gpio_in_one_cycle: got %h want 00", d_mem_rdata); end
    step();
    rd(DMEM_GPIO_IN);
    checks++; if (d_mem_rdata !== 8'h3C) begin errors++; $display("FAIL gpio_in_two_cycles: got %h want 3C", d_mem_rdata); end
    wr_step(DMEM_GPIO_IN, 8'hFF);
    rd(DMEM_GPIO_IN);
    checks++; if (d_mem_rdata !== 8'h3C) begin errors++; $display("FAIL gpio_in_write_ignored: got %h want 3C", d_mem_rdata); end
    idle();
  endtask

`ifdef DMEM_TIMER_EN
  task automatic test_timer();
    int n;
    bit found;
    wr_step(DMEM_TMR_RELOAD, 8'd2);
    wr(DMEM_TMR_CTRL, 8'h03); step();
    rd(DMEM_TMR_CNT);
    checks++; if (d_mem_rdata !== 8'd2) begin errors++; $display("FAIL tmr_cnt_loaded: got %h want 02", d_mem_rdata); end
    wait_pend(40, n, found);
    checks++; if (!found || n != 12) begin errors++; $display("FAIL tmr_first_expiry: got %0d cycles (seen=%0d) want 12", n, found); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL tmr_irq_lag: got %b want 0", timer_irq); end
    step();
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL tmr_irq_set: got %b want 1", timer_irq); end
    wr(DMEM_TMR_CTRL, 8'h07); step();
    rd(DMEM_TMR_CTRL);
    checks++; if (d_mem_rdata !== 8'h03) begin errors++; $display("FAIL tmr_pend_w1c: got %h want 03", d_mem_rdata); end
    step();
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL tmr_irq_clear: got %b want 0", timer_irq); end
    wait_pend(40, n, found);
    checks++; if (!found || n + 3 != 12) begin errors++; $display("FAIL tmr_second_expiry: got %0d cycles (seen=%0d) want 12", n + 3, found); end
    // Reload of zero expires on every prescaler wrap.
    wr_step(DMEM_TMR_CTRL, 8'h04);
    wr_step(DMEM_TMR_RELOAD, 8'h00);
    wr(DMEM_TMR_CTRL, 8'h01); step();
    wait_pend(40, n, found);
    checks++; if (!found || n != PRESCALE) begin errors++; $display("FAIL tmr_zero_first: got %0d cycles (seen=%0d) want %0d", n, found, PRESCALE); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL tmr_irq_masked: got %b want 0", timer_irq); end
    wr(DMEM_TMR_CTRL, 8'h05); step();
    rd(DMEM_TMR_CTRL);
    checks++; if (d_mem_rdata !== 8'h01) begin errors++; $display("FAIL tmr_zero_w1c: got %h want 01", d_mem_rdata); end
    wait_pend(40, n, found);
    checks++; if (!found || n + 5 != 2 * PRESCALE) begin errors++; $display("FAIL tmr_zero_second: got %0d cycles (seen=%0d) want %0d", n + 5, found, 2 * PRESCALE); end
    idle();
  endtask
`else
  task automatic test_timer();
    wr_step(DMEM_TMR_RELOAD, 8'h12);
    wr_step(DMEM_TMR_CTRL, 8'h03);
    repeat (20) step();
    rd(DMEM_TMR_RELOAD);
    checks++; if (d_mem_rdata !== 8'h00) begin errors++; $display("FAIL notmr_reload: got %h want 00", d_mem_rdata); end
    rd(DMEM_TMR_CTRL);
    checks++; if (d_mem_rdata !== 8'h00) begin errors++; $display("FAIL notmr_ctrl: got %h want 00", d_mem_rdata); end
    rd(DMEM_TMR_CNT);
    checks++; if (d_mem_rdata !== 8'h00) begin errors++; $display("FAIL notmr_cnt: got %h want 00", d_mem_rdata); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL notmr_irq: got %b want 0", timer_irq); end
    idle();
  endtask
`endif

  task automatic test_random();
    bit exp_err;
    wr_step(DMEM_ERR, 8'h01);
    exp_err = 1'b0;
    for (int i = 0; i < 300; i++) begin
      int unsigned op;
      logic [11:0] a;
      logic [7:0]  d;
      op = $urandom_range(0, 9);
      if (op < 4) begin
        a = 12'($urandom_range(16'h010, 16'h03F));
        d = 8'($urandom);
        wr(a, d); step(); idle();
        mdl[int'(a)] = d;
      end else if (op < 8) begin
        a = 12'($urandom_range(16'h010, 16'h03F));
        rd(a);
        if (mdl.exists(int'(a))) begin
          checks++; if (d_mem_rdata !== mdl[int'(a)]) begin errors++; $display("FAIL rand_ram_read @%h: got %h want %h", a, d_mem_rdata, mdl[int'(a)]); end
        end
        step(); idle();
      end else if (op == 8) begin
        a = 12'($urandom_range(16'h800, 16'hFFF));
        rd(a);
        checks++; if (d_mem_rdata !== 8'hFF) begin errors++; $display("FAIL rand_oor_read @%h: got %h want FF", a, d_mem_rdata); end
        step(); idle();
        exp_err = 1'b1;
      end else begin
        wr(DMEM_ERR, 8'h01); step(); idle();
        exp_err = 1'b0;
      end
      checks++; if (bus_err !== exp_err) begin errors++; $display("FAIL rand_bus_err iter %0d: got %b want %b", i, bus_err, exp_err); end
    end
    wr_step(DMEM_ERR, 8'h01);
  endtask

  task automatic test_reset_mid();
`ifdef DMEM_TIMER_EN
    wr_step(DMEM_TMR_CTRL, 8'h04);
    wr_step(DMEM_TMR_RELOAD, 8'd3);
    wr(DMEM_TMR_CTRL, 8'h03); step();
    rd(12'hFFF); step(); idle();
    repeat (16) step();
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b want 1", timer_irq); end
    rd(DMEM_TMR_CNT);
    checks++; if (d_mem_rdata !== 8'd3) begin errors++; $display("FAIL pre_reset_cnt: got %h want 03", d_mem_rdata); end
`else
    rd(12'hFFF); step(); idle();
    repeat (3) step();
`endif
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL pre_reset_bus_err: got %b want 1", bus_err); end
    checks++; if (gpio_out !== 8'h5A) begin errors++; $display("FAIL pre_reset_gpio: got %h want 5A", gpio_out); end
    #2;
    reset = 1'b1;
    rd(DMEM_TMR_CNT);
    checks++; if (d_mem_rdata !== 8'h00) begin errors++; $display("FAIL mid_reset_cnt: got %h want 00", d_mem_rdata); end
    checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL mid_reset_gpio: got %h want 00", gpio_out); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq: got %b want 0", timer_irq); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL mid_reset_bus_err: got %b want 0", bus_err); end
    wr(DMEM_GPIO_OUT, 8'h77); step(); idle();
    @(negedge clk) reset = 1'b0;
    step();
    checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL write_during_reset_dropped: got %h want 00", gpio_out); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ram_roundtrip();
    test_stack();
    test_bus_err_range();
    test_bus_err_rdwr();
    test_low_addr();
    test_gpio();
    test_timer();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder (target) side of the CPU data-memory bus driven by the execute unit.
- Contains the data RAM and a small memory-mapped peripheral window at 0x008–0x00F: GPIO, a reload timer, and an error/status register.
- Reads are combinational, so the execute unit captures read data in the same cycle it asserts rd. This covers both load data and return-address pops.
- Writes commit on the rising clock edge.

Parameters:
- RAM_DEPTH, 2048, number of bytes of RAM decoded (addresses 0x000..RAM_DEPTH-1; 0x000–0x00F are never RAM).
- PRESCALE, 16, clk cycles per timer tick (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- d_mem_en  in  1  access qualifier from execute.
- d_mem_rd  in  1  read strobe.
- d_mem_wr  in  1  write strobe.
- d_mem_addr  in  12  byte address.
- d_mem_wdata  in  8  write data (execute d_mem_data_out).
- d_mem_rdata  out  8  read data (execute d_mem_data_in).
- gpio_in  in  8  asynchronous inputs.
- gpio_out  out  8  GPIO output register.
- timer_irq  out  1  timer interrupt request.
- bus_err  out  1  sticky access-error flag.

Behaviour:
- Access = d_mem_en & (d_mem_rd | d_mem_wr).
- Read, combinational, valid in the cycle of d_mem_en & d_mem_rd:
  - 0x008 GPIO_OUT, 0x009 GPIO_IN_SYNC, 0x00A TMR_CNT, 0x00B TMR_RELOAD.
  - 0x00C TMR_CTRL = {5'b0, pend, irq_en, run}.
  - 0x00D ERR = {7'b0, bus_err}.
  - 0x00E/0x00F read 0x00.
  - 0x010..RAM_DEPTH-1 return RAM.
  - Any other address returns 0xFF.
  - d_mem_rdata = 0x00 when there is no read.
- Write at posedge when d_mem_en & d_mem_wr:
  - RAM: byte written.
  - GPIO_OUT: loaded.
  - TMR_RELOAD: loaded; takes effect at the next reload only.
  - TMR_CTRL: bits[1:0] written; bit2 written 1 clears pend (write-1-to-clear).
  - ERR: writing bit0=1 clears bus_err.
  - GPIO_IN, TMR_CNT, 0x00E/0x00F: writes ignored.
- Read-during-write to the same RAM address returns the old data. The new value is visible from the next cycle.
- bus_err is set on either of:
  - an access to address >= RAM_DEPTH (outside 0x000–0x00F);
  - d_mem_en with rd and wr both high. The write is still performed; read returns the old value.
- If a set condition and a clear write coincide, set wins.
- Address 0x000–0x007 is never presented with d_mem_en by execute. If it is, reads return 0x00, writes are ignored, and no error is flagged.
- GPIO_IN_SYNC: 2-flop synchronizer, 2-cycle latency.
- Timer:
  - Prescaler counts 0..PRESCALE-1 while run=1 and emits one tick at wrap.
  - Prescaler is held at 0 while run=0.
  - On tick: if TMR_CNT == 0, load TMR_RELOAD and set pend; else decrement.
  - Writing run 0→1 loads TMR_CNT from TMR_RELOAD and clears the prescaler.
  - RELOAD = 0 sets pend on every tick.
  - A pend-set and a W1C in the same cycle leave pend = 1.
- timer_irq = pend & irq_en, registered. Asserted 1 cycle after pend sets and held until cleared.
- Reset values:
  - d_mem_rdata=0 (combinational), gpio_out=0x00, timer_irq=0, bus_err=0.
  - TMR_CNT=0, TMR_RELOAD=0xFF, TMR_CTRL=0, synchronizer=0.
  - RAM contents are undefined (not reset).
- Reset asserted mid-operation clears all registers immediately. A write coincident with reset is dropped.

Optional Feature:
- DMEM_TIMER_EN
- Defined: timer, prescaler and timer_irq are implemented as above.
- Undefined:
  - 0x00A–0x00C read 0x00 and writes are ignored.
  - timer_irq is tied to 0.
  - PRESCALE is unused.
  - No timer flops are synthesized.

Decomposition:
- Shared package / defines header:
  - MMIO address constants (DMEM_GPIO_OUT=12'h008 … DMEM_ERR=12'h00D);
  - DMEM_RAM_BASE=12'h010;
  - TMR_CTRL bit positions (RUN=0, IRQ_EN=1, PEND=2).
- Sub-module: dmem_timer (prescaler, counter, reload, pend, irq), instantiated under DMEM_TIMER_EN.

Test Plan:
- RAM round-trip: write 0xA5 @0x123; read @0x123 next cycle → 0xA5. Read @0x123 in the write cycle → prior value.
- Stack pattern: wr 0x34 @0x200, wr 0x01 @0x201 in consecutive cycles; then rd 0x201, 0x200 in consecutive cycles → 0x01, 0x34 combinationally each cycle.
- Bus error, out of range: RAM_DEPTH=2048, rd @0x900 → rdata 0xFF, bus_err=1 next cycle. Write 0x01 @0x00D → bus_err=0.
- Bus error, rd+wr: d_mem_en with rd=wr=1 @0x050, wdata 0x77 → bus_err=1, RAM[0x050]=0x77.
- Timer: PRESCALE=4, write RELOAD=2, CTRL=0x03 → pend after (2+1)×4 = 12 cycles, timer_irq 1 cycle later. Write CTRL=0x07 → irq drops. Next expiry again 12 cycles later.
- GPIO/reset: write 0x5A @0x008 → gpio_out=0x5A. Drive gpio_in=0x3C → read @0x009 returns 0x3C after 2 cycles. Assert reset mid-timer-count → gpio_out=0, timer_irq=0, TMR_CNT=0 immediately.
